// File: rtl/nios_led_pwm_pio.sv
// nios_led_pwm_pio
//   Avalon-MM LED/indicator port with WIDTH output channels. Each channel is
//   either a static level taken from DATA or a PWM dimming output compared
//   against a shared prescaled counter. SET/CLEAR/TOGGLE give firmware atomic
//   bit updates without read-modify-write.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   address    register word address (0..7)
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data (unused bits ignored)
//   readdata   read data, combinational from address (zero wait states)
//   out_port   registered channel outputs
//
// Register map
//   0 DATA  1 MODE  2 SET  3 CLEAR  4 TOGGLE  5 PRESCALE  6 DUTY_SEL  7 DUTY
module nios_led_pwm_pio #(
  parameter int WIDTH         = 8,
  parameter int PWM_BITS      = 8,
  parameter int PRESCALE_BITS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [WIDTH-1:0]  out_port
);

  logic                     wr;
  logic [WIDTH-1:0]         data_q;
  logic [WIDTH-1:0]         mode_q;
  logic [PRESCALE_BITS-1:0] prescale_q;
  logic [4:0]               duty_sel_q;
  logic [PWM_BITS-1:0]      duty_q [WIDTH];
  logic [PRESCALE_BITS-1:0] pre_cnt;
  logic [PWM_BITS-1:0]      pwm_cnt;
  logic                     tick;
  logic [WIDTH-1:0]         chan_next;

  assign wr   = chipselect & ~write_n;
  assign tick = (pre_cnt == prescale_q);

  // Register file. DUTY writes are steered by DUTY_SEL; a selector that
  // matches no channel simply leaves every duty register untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q     <= '0;
      mode_q     <= '0;
      prescale_q <= '0;
      duty_sel_q <= '0;
      for (int i = 0; i < WIDTH; i++) duty_q[i] <= '0;
    end else if (wr) begin
      case (address)
        3'd0: data_q     <= writedata[WIDTH-1:0];
        3'd1: mode_q     <= writedata[WIDTH-1:0];
        3'd2: data_q     <= data_q | writedata[WIDTH-1:0];
        3'd3: data_q     <= data_q & ~writedata[WIDTH-1:0];
        3'd4: data_q     <= data_q ^ writedata[WIDTH-1:0];
        3'd5: prescale_q <= writedata[PRESCALE_BITS-1:0];
        3'd6: duty_sel_q <= writedata[4:0];
        3'd7: begin
          for (int i = 0; i < WIDTH; i++) begin
            if (duty_sel_q == 5'(i)) duty_q[i] <= writedata[PWM_BITS-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Shared timebase. A PRESCALE write restarts both counters so the new
  // period begins cleanly from phase zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else if (wr && (address == 3'd5)) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end else begin
      pre_cnt <= pre_cnt + PRESCALE_BITS'(1);
    end
  end

  // Duty 0 never satisfies the compare, so a zero duty is always off.
  always_comb begin
    chan_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      chan_next[i] = mode_q[i] ? (pwm_cnt < duty_q[i]) : data_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) out_port <= '0;
    else       out_port <= chan_next;
  end

  // Read mux shows register contents as they stand before any same-cycle write.
  always_comb begin
    readdata = '0;
    case (address)
      3'd0: readdata = 32'(data_q);
      3'd1: readdata = 32'(mode_q);
      3'd5: readdata = 32'(prescale_q);
      3'd6: readdata = 32'(duty_sel_q);
      3'd7: begin
        for (int i = 0; i < WIDTH; i++) begin
          if (duty_sel_q == 5'(i)) readdata = 32'(duty_q[i]);
        end
      end
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_nios_led_pwm_pio.sv
// tb_nios_led_pwm_pio
//   Directed bench for nios_led_pwm_pio (WIDTH=8, PWM_BITS=8, PRESCALE_BITS=16).
//   A behavioural model tracks the register file and derives the PWM phase
//   from the number of clock edges since the timebase last restarted.
module tb_nios_led_pwm_pio;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  nios_led_pwm_pio #(.WIDTH(8), .PWM_BITS(8), .PRESCALE_BITS(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model state
  logic [7:0]  m_data, m_mode;
  logic [15:0] m_pre;
  logic [4:0]  m_sel;
  int          m_duty [8];
  longint      m_elapsed;

  int          hi_cnt = 0;
  int          cnt_ch = 0;
  logic [31:0] last_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return {24'd0, m_data};
      3'd1: return {24'd0, m_mode};
      3'd5: return {16'd0, m_pre};
      3'd6: return {27'd0, m_sel};
      3'd7: return (m_sel < 5'd8) ? 32'(m_duty[m_sel]) : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // PWM phase = whole prescale periods elapsed, modulo the 256-tick period.
  function automatic logic [7:0] model_out();
    logic [7:0] r;
    longint pwm;
    pwm = (m_elapsed / (longint'(m_pre) + 1)) % 256;
    for (int i = 0; i < 8; i++)
      r[i] = m_mode[i] ? (pwm < longint'(m_duty[i])) : m_data[i];
    return r;
  endfunction

  task automatic step(input logic r, input logic cs, input logic wn,
                      input logic [2:0] a, input logic [31:0] d);
    logic [7:0] exp_out;
    @(negedge clk);
    reset = r; chipselect = cs; write_n = wn; address = a; writedata = d;
    #1;
    if (cs && wn && !r) begin
      chk($sformatf("read addr %0d", a), readdata, model_read(a));
      last_rd = readdata;
    end
    exp_out = model_out();
    @(posedge clk);
    if (r) begin
      m_data = '0; m_mode = '0; m_pre = '0; m_sel = '0;
      for (int i = 0; i < 8; i++) m_duty[i] = 0;
      m_elapsed = 0;
      exp_out = '0;
    end else begin
      m_elapsed++;
      if (cs && !wn) begin
        case (a)
          3'd0: m_data = d[7:0];
          3'd1: m_mode = d[7:0];
          3'd2: m_data = m_data | d[7:0];
          3'd3: m_data = m_data & ~d[7:0];
          3'd4: m_data = m_data ^ d[7:0];
          3'd5: begin m_pre = d[15:0]; m_elapsed = 0; end
          3'd6: m_sel = d[4:0];
          3'd7: if (m_sel < 5'd8) m_duty[m_sel] = int'(d[7:0]);
          default: ;
        endcase
      end
    end
    #1;
    chk("out_port", {24'd0, out_port}, {24'd0, exp_out});
    hi_cnt += int'(out_port[cnt_ch]);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d); step(1'b0, 1'b1, 1'b0, a, d); endtask
  task automatic rd(input logic [2:0] a); step(1'b0, 1'b1, 1'b1, a, 32'd0); endtask
  task automatic idle(input int n); for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b1, 3'd0, 32'd0); endtask
  task automatic do_rst(); step(1'b1, 1'b0, 1'b1, 3'd0, 32'd0); endtask

  initial begin
    m_data = '0; m_mode = '0; m_pre = '0; m_sel = '0; m_elapsed = 0;
    for (int i = 0; i < 8; i++) m_duty[i] = 0;
    last_rd = '0;

    // Reset and static DATA
    do_rst();
    chk("reset out_port", {24'd0, out_port}, 32'd0);
    wr(3'd0, 32'hFFFF_FFA5);
    idle(1);
    chk("data A5 out", {24'd0, out_port}, 32'h0000_00A5);
    rd(3'd0);
    chk("data A5 read", last_rd, 32'h0000_00A5);

    // Atomic bit operations
    wr(3'd0, 32'h0F);
    wr(3'd2, 32'h30); idle(1);
    chk("set out", {24'd0, out_port}, 32'h3F);
    wr(3'd3, 32'h03); idle(1);
    chk("clear out", {24'd0, out_port}, 32'h3C);
    wr(3'd4, 32'hFF); idle(1);
    chk("toggle out", {24'd0, out_port}, 32'hC3);
    rd(3'd2); chk("set reads 0", last_rd, 32'd0);
    rd(3'd3); chk("clear reads 0", last_rd, 32'd0);
    rd(3'd4); chk("toggle reads 0", last_rd, 32'd0);

    // PWM on channel 2, prescale 0: 64 high cycles per 256
    wr(3'd5, 32'd0);
    wr(3'd6, 32'd2);
    wr(3'd7, 32'd64);
    wr(3'd1, 32'h04);
    cnt_ch = 2; hi_cnt = 0;
    idle(256);
    chk("ch2 high per 256", 32'(hi_cnt), 32'd64);

    // Channel 0, prescale 3: 1024-cycle period
    wr(3'd5, 32'd3);
    wr(3'd6, 32'd0);
    wr(3'd7, 32'd128);
    wr(3'd1, 32'h01);
    cnt_ch = 0; hi_cnt = 0;
    idle(1024);
    chk("duty128 high per 1024", 32'(hi_cnt), 32'd512);
    wr(3'd7, 32'd0);
    hi_cnt = 0;
    idle(1024);
    chk("duty0 high per 1024", 32'(hi_cnt), 32'd0);
    wr(3'd7, 32'd255);
    hi_cnt = 0;
    idle(1024);
    chk("duty255 low per 1024", 32'(1024 - hi_cnt), 32'd4);

    // Out-of-range duty selector
    wr(3'd6, 32'd9);
    wr(3'd7, 32'h55);
    rd(3'd7);
    chk("duty sel 9 read", last_rd, 32'd0);
    for (int i = 0; i < 8; i++) begin
      wr(3'd6, 32'(i));
      rd(3'd7);
    end
    wr(3'd6, 32'd2); rd(3'd7);
    chk("duty2 kept", last_rd, 32'd64);

    // Reset in the middle of PWM
    wr(3'd1, 32'h05);
    idle(50);
    do_rst();
    chk("mid reset out", {24'd0, out_port}, 32'd0);
    rd(3'd1); chk("mode after reset", last_rd, 32'd0);
    rd(3'd0); chk("data after reset", last_rd, 32'd0);
    rd(3'd7); chk("duty after reset", last_rd, 32'd0);
    wr(3'd7, 32'd100);
    wr(3'd1, 32'h01);
    cnt_ch = 0; hi_cnt = 0;
    idle(256);
    chk("post-reset duty100 high", 32'(hi_cnt), 32'd100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
